// File: rtl/mux_select_ctrl_pkg.sv
// Shared defaults for the 4:1 byte mux select path and a width helper.
// Combinational definitions only; no latency, no backpressure.
package mux_select_ctrl_pkg;

    localparam int DEF_NUM_INPUTS      = 4;
    localparam int DEF_SEL_WIDTH       = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_SCAN_CYCLES     = 1000;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_NEXT,
        STEP_PREV,
        STEP_CANCEL
    } step_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser, debounce counter and registered press pulse for one button.
// Press pulse follows the raw rise by DEBOUNCE_CYCLES+2 edges; no backpressure.
module button_debounce
    import mux_select_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press
);

    localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        // Any agreeing edge clears the count, so only an unbroken run flips the state.
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = ~stable_q;
                press_d  = ~stable_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign btn_level = stable_q;
    assign btn_press = press_q;

endmodule

// File: rtl/mux_select_ctrl.sv
// Wrap-around mux select driven by debounced next/prev buttons and an auto-scan dwell timer.
// select/sel_changed update one edge after a press pulse or dwell expiry; no backpressure.
module mux_select_ctrl
    import mux_select_ctrl_pkg::*;
#(
    parameter int NUM_INPUTS      = DEF_NUM_INPUTS,
    parameter int SEL_WIDTH       = DEF_SEL_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SCAN_CYCLES     = DEF_SCAN_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 btn_next,
    input  logic                 btn_prev,
    input  logic                 auto_en,
    output logic [SEL_WIDTH-1:0] select,
    output logic                 sel_changed
);

    localparam int                   DW        = cnt_width(SCAN_CYCLES);
    localparam logic [DW-1:0]        DWELL_MAX = DW'(SCAN_CYCLES - 1);
    localparam logic [SEL_WIDTH-1:0] SEL_LAST  = SEL_WIDTH'(NUM_INPUTS - 1);

    logic next_level, next_press;
    logic prev_level, prev_press;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_next),
        .btn_level (next_level),
        .btn_press (next_press)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_prev),
        .btn_level (prev_level),
        .btn_press (prev_press)
    );

    function automatic logic [SEL_WIDTH-1:0] sel_inc(input logic [SEL_WIDTH-1:0] s);
        return (s == SEL_LAST) ? '0 : s + SEL_WIDTH'(1);
    endfunction

    function automatic logic [SEL_WIDTH-1:0] sel_dec(input logic [SEL_WIDTH-1:0] s);
        return (s == '0) ? SEL_LAST : s - SEL_WIDTH'(1);
    endfunction

    step_t                step;
    logic [SEL_WIDTH-1:0] select_q, select_d;
    logic                 changed_q, changed_d;
    logic [DW-1:0]        dwell_q, dwell_d;

    always_comb begin
        case ({next_press, prev_press})
            2'b11:   step = STEP_CANCEL;
            2'b10:   step = STEP_NEXT;
            2'b01:   step = STEP_PREV;
            default: step = STEP_NONE;
        endcase
    end

    // Every non-idle step leaves dwell at zero, so a button beats a coincident auto advance.
    always_comb begin
        select_d = select_q;
        dwell_d  = '0;
        case (step)
            STEP_NEXT: select_d = sel_inc(select_q);
            STEP_PREV: select_d = sel_dec(select_q);
            STEP_NONE: begin
                if (auto_en) begin
                    if (dwell_q == DWELL_MAX) begin
                        select_d = sel_inc(select_q);
                    end else begin
                        dwell_d = dwell_q + DW'(1);
                    end
                end
            end
            default: select_d = select_q;
        endcase
        changed_d = (select_d != select_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            select_q  <= '0;
            changed_q <= 1'b0;
            dwell_q   <= '0;
        end else begin
            select_q  <= select_d;
            changed_q <= changed_d;
            dwell_q   <= dwell_d;
        end
    end

    a_next_press_level: assert property (@(posedge clk) disable iff (!rst_n) next_press |-> next_level);
    a_prev_press_level: assert property (@(posedge clk) disable iff (!rst_n) prev_press |-> prev_level);

    assign select      = select_q;
    assign sel_changed = changed_q;

endmodule

// File: tb/tb_mux_select_ctrl.sv
// Bench for mux_select_ctrl: 4-input and 3-input instances share stimulus and are
// checked every cycle against a history-based model, plus directed literal checks.
module tb_mux_select_ctrl;
    import mux_select_ctrl_pkg::*;

    localparam int DB   = 4;
    localparam int SCAN = 10;

    logic       clk = 1'b0;
    logic       rst_n, btn_next, btn_prev, auto_en;
    logic [1:0] sel4, sel3;
    logic       chg4, chg3;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mux_select_ctrl #(
        .NUM_INPUTS(4), .SEL_WIDTH(2), .DEBOUNCE_CYCLES(DB), .SCAN_CYCLES(SCAN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_next(btn_next), .btn_prev(btn_prev),
        .auto_en(auto_en), .select(sel4), .sel_changed(chg4)
    );

    mux_select_ctrl #(
        .NUM_INPUTS(3), .SEL_WIDTH(2), .DEBOUNCE_CYCLES(DB), .SCAN_CYCLES(SCAN)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .btn_next(btn_next), .btn_prev(btn_prev),
        .auto_en(auto_en), .select(sel3), .sel_changed(chg3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // hist[0] is the raw level sampled at the previous edge, hist[1] the synchronised
    // level seen at this edge, hist[1..DB] the synchronised levels of the last DB edges.
    bit hist_n [0:DB];
    bit hist_p [0:DB];
    bit st_n, st_p, pend_n, pend_p, mvalid;
    int m_sel [2];
    bit m_chg [2];
    int nin   [2] = '{4, 3};
    int dwell;

    function automatic bit all_differ(input bit h [0:DB], input bit st);
        for (int i = 1; i <= DB; i++) if (h[i] == st) return 1'b0;
        return 1'b1;
    endfunction

    initial mvalid = 1'b0;

    always @(posedge clk) begin
        int adv;
        if (!rst_n) begin
            for (int i = 0; i <= DB; i++) begin hist_n[i] = 0; hist_p[i] = 0; end
            st_n = 0; st_p = 0; pend_n = 0; pend_p = 0; dwell = 0;
            for (int d = 0; d < 2; d++) begin m_sel[d] = 0; m_chg[d] = 0; end
            mvalid = 1'b1;
        end else begin
            if (pend_n && pend_p)  begin adv = 0;  dwell = 0; end
            else if (pend_n)       begin adv = 1;  dwell = 0; end
            else if (pend_p)       begin adv = -1; dwell = 0; end
            else if (auto_en) begin
                if (dwell == SCAN - 1) begin adv = 1; dwell = 0; end
                else begin adv = 0; dwell++; end
            end else begin adv = 0; dwell = 0; end
            for (int d = 0; d < 2; d++) begin
                m_chg[d] = (adv != 0);
                m_sel[d] = (m_sel[d] + adv + nin[d]) % nin[d];
            end
            pend_n = 0;
            if (all_differ(hist_n, st_n)) begin pend_n = !st_n; st_n = !st_n; end
            pend_p = 0;
            if (all_differ(hist_p, st_p)) begin pend_p = !st_p; st_p = !st_p; end
            for (int i = DB; i >= 1; i--) begin hist_n[i] = hist_n[i-1]; hist_p[i] = hist_p[i-1]; end
            hist_n[0] = btn_next;
            hist_p[0] = btn_prev;
        end
        #1;
        if (mvalid) begin
            chk("model_sel4", sel4, m_sel[0]);
            chk("model_chg4", chg4, m_chg[0]);
            chk("model_sel3", sel3, m_sel[1]);
            chk("model_chg3", chg3, m_chg[1]);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit nxt);
        if (nxt) btn_next = 1'b1; else btn_prev = 1'b1;
        step(8);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        step(8);
    endtask

    initial begin
        rst_n = 1'b0; btn_next = 1'b0; btn_prev = 1'b0; auto_en = 1'b0;
        step(3);
        chk("reset_sel4", sel4, 0);
        chk("reset_chg4", chg4, 0);
        chk("reset_sel3", sel3, 0);
        rst_n = 1'b1;
        step(2);

        // clean press: step lands on the 7th edge after the raise
        btn_next = 1'b1;
        step(6); chk("clean_before", sel4, 0);
        step(1); chk("clean_sel", sel4, 1); chk("clean_chg", chg4, 1);
        step(1); chk("clean_chg_drop", chg4, 0);
        step(50); chk("held_no_repeat", sel4, 1);
        btn_next = 1'b0;
        step(10);

        // bounce, then a clean hold
        for (int i = 0; i < 5; i++) begin
            btn_next = 1'b1; step(2);
            btn_next = 1'b0; step(2);
        end
        btn_next = 1'b1;
        step(6); chk("bounce_before", sel4, 1);
        step(1); chk("bounce_sel", sel4, 2); chk("bounce_chg", chg4, 1);
        step(5);
        btn_next = 1'b0;
        step(10);

        // 3-cycle glitch is rejected
        btn_next = 1'b1; step(3); btn_next = 1'b0;
        step(12); chk("glitch_sel", sel4, 2);

        // wrap both directions on both instances
        press(1'b1); chk("wrap_n4_a", sel4, 3); chk("wrap_n3_a", sel3, 0);
        press(1'b1); chk("wrap_n4_b", sel4, 0); chk("wrap_n3_b", sel3, 1);
        press(1'b0); chk("wrap_p4_a", sel4, 3); chk("wrap_p3_a", sel3, 0);
        press(1'b0); chk("wrap_p4_b", sel4, 2); chk("wrap_p3_b", sel3, 2);

        // simultaneous press cancels
        btn_next = 1'b1; btn_prev = 1'b1;
        step(20); chk("simul_sel4", sel4, 2); chk("simul_sel3", sel3, 2);
        btn_next = 1'b0; btn_prev = 1'b0;
        step(10);

        // auto-scan from a fresh reset
        rst_n = 1'b0; step(2);
        rst_n = 1'b1; auto_en = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            step(9); chk("auto_hold", sel4, (v - 1) % 4);
            step(1); chk("auto_step", sel4, v % 4); chk("auto_chg", chg4, 1);
        end
        // press lands exactly on the 50th auto edge
        step(3); btn_next = 1'b1;
        step(6); chk("coinc_before", sel4, 0);
        step(1); chk("coinc_sel", sel4, 1); chk("coinc_sel3", sel3, 2);
        step(9); chk("coinc_hold", sel4, 1);
        step(1); chk("coinc_next_auto", sel4, 2);
        btn_next = 1'b0; auto_en = 1'b0;
        step(10);

        // reset during debounce count 2 and dwell 7
        auto_en = 1'b1;
        step(3); btn_next = 1'b1;
        step(4);
        rst_n = 1'b0;
        step(2); chk("midrst_sel4", sel4, 0); chk("midrst_chg4", chg4, 0); chk("midrst_sel3", sel3, 0);
        rst_n = 1'b1;
        step(6); chk("midrst_before", sel4, 0);
        step(1); chk("midrst_press", sel4, 1);
        step(9); chk("midrst_dwell", sel4, 1);
        step(1); chk("midrst_auto", sel4, 2);
        btn_next = 1'b0; auto_en = 1'b0;
        step(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_select_ctrl.md
Name: mux_select_ctrl

Overview:
- Upstream control stage for the async 4:1 byte mux; generates its `select` bus from two raw push buttons (next/prev) plus an optional auto-scan timer.
- Synchronises and debounces the buttons, converts clean presses into wrap-around select steps, and flags every change.
- Output `select` connects directly to the mux `select` input.

Parameters:
- NUM_INPUTS, 4: number of mux inputs; select wraps modulo NUM_INPUTS; legal range 2..2**SEL_WIDTH.
- SEL_WIDTH, 2: width of `select`.
- DEBOUNCE_CYCLES, 4: consecutive clocks a synchronised button level must differ from the debounced state before it is accepted; must be >= 1.
- SCAN_CYCLES, 1000: auto-scan dwell in clocks per select value; must be >= 2.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on the clk rising edge.
- btn_next  input  1  raw, asynchronous, active-high "next" button; may bounce.
- btn_prev  input  1  raw, asynchronous, active-high "previous" button; may bounce.
- auto_en  input  1  synchronous level; 1 enables auto-scan.
- select  output  SEL_WIDTH  registered mux select.
- sel_changed  output  1  registered one-cycle pulse, high in the same cycle `select` first shows a new value.

Behaviour:
- Reset: synchronous, active-low. While rst_n=0 at a clk edge, all state clears.
  - select=0, sel_changed=0.
  - Synchroniser flops, debounced states, debounce counters, press pulses and dwell counter all 0.
  - Reset asserted mid-debounce or mid-dwell discards all progress; there is no partial carry-over.
- Synchroniser: two flops per button. The first edge samples the raw level (edge E0); the synchronised level is valid after E1.
- Debounce, per button:
  - Keep a stable state and a counter.
  - At each edge where the synchronised level differs from stable: cnt++.
  - When cnt==DEBOUNCE_CYCLES-1 on such an edge: stable flips and cnt clears.
  - At any edge where the levels agree: cnt clears.
  - Glitches shorter than DEBOUNCE_CYCLES clocks are therefore ignored.
- Press detect: a registered one-cycle pulse on each stable 0->1 transition. Releases (1->0) produce no event.
- Latency: select updates on edge E(DEBOUNCE_CYCLES+2), i.e. the (DEBOUNCE_CYCLES+3)th rising edge, counting E0 as the first edge sampling raw high. sel_changed is high for exactly the following cycle.
- Select update, priority per cycle:
  1. next and prev pulses together: no change, sel_changed=0, dwell counter cleared.
  2. next only: select = (select==NUM_INPUTS-1) ? 0 : select+1.
  3. prev only: select = (select==0) ? NUM_INPUTS-1 : select-1.
  4. Otherwise, auto-scan advance if due (same arithmetic as next).
- Auto-scan:
  - While auto_en=1, the dwell counter increments every clock.
  - When dwell==SCAN_CYCLES-1: advance select as for next, clear dwell.
  - Any button step, or a simultaneous-press cancel, clears dwell, so the button wins over a coincident auto advance.
  - auto_en=0 holds dwell at 0. Re-enabling gives a full SCAN_CYCLES dwell before the first advance.
- sel_changed asserts only when select actually takes a new value; it is never high with select unchanged.
- Held button: exactly one step per debounced press; there is no auto-repeat.

Decomposition:
- Shared include holds the default widths and timing constants (NUM_INPUTS, SEL_WIDTH, DEBOUNCE_CYCLES, SCAN_CYCLES defaults), common with the mux and its bench.
- One sub-module: button_debounce (2-flop synchroniser + debounce counter + registered rising-edge pulse; parameter DEBOUNCE_CYCLES; ports clk, rst_n, btn_raw, btn_level, btn_press). It is instantiated twice.
- Top level holds the select/dwell logic only.

Test Plan:
- Reset/clean press: hold rst_n=0 for 3 edges, release; DEBOUNCE_CYCLES=4. Raise btn_next clean -> select 0->1 on the 7th edge after raise, sel_changed high exactly 1 cycle. Hold the button 50 cycles -> no further step.
- Bounce: btn_next toggles high/low every 2 clocks for 20 clocks, then held high -> exactly one step, occurring 7 edges after the final rise. A 3-cycle glitch alone -> no step.
- Wrap: from select=3, press next -> 0. Press prev -> 3. With NUM_INPUTS=3: next from 2 -> 0, prev from 0 -> 2.
- Simultaneous: btn_next and btn_prev raised on the same edge -> select unchanged, sel_changed stays 0.
- Auto-scan: SCAN_CYCLES=10, auto_en=1 -> select steps 0,1,2,3,0 every 10 clocks with a 1-cycle sel_changed each. A next press landing on the advance cycle -> single step, next auto step 10 clocks later.
- Reset mid-operation: assert rst_n=0 during debounce count 2 and dwell 7 -> select=0, sel_changed=0. After release, a full 7-edge debounce and 10-clock dwell are required again.
